// File: rtl/lcd_pkg.sv
// Shared definitions for the 8080-style LCD writer: FSM encodings and default
// bus timing / opcode values.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REG_WR  = 3'd1,
    ST_FRM_CMD = 3'd2,
    ST_STREAM  = 3'd3,
    ST_PIX_WR  = 3'd4,
    ST_DONE    = 3'd5
  } lcd_state_e;

  localparam int unsigned WR_LOW_DEF    = 32'd2;
  localparam int unsigned WR_HIGH_DEF   = 32'd2;
  localparam logic [15:0] MEMWR_CMD_DEF = 16'h002C;

endpackage

// File: rtl/lcd_wr_strobe.sv
// Timing engine for one bus write: latches rs/data on go, drives wr_n low for
// WR_LOW cycles then high for WR_HIGH cycles, pulses done in the final cycle.
module lcd_wr_strobe
  import lcd_pkg::*;
#(
  parameter int unsigned WR_LOW  = WR_LOW_DEF,
  parameter int unsigned WR_HIGH = WR_HIGH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        rs_in,
  input  logic [15:0] data_in,
  output logic        wr_n,
  output logic        rs_out,
  output logic [15:0] data_out,
  output logic        done
);

  localparam int unsigned TOTAL = WR_LOW + WR_HIGH;
  localparam int unsigned CW    = $clog2(TOTAL);
  localparam logic [CW-1:0] CNT_LOAD = CW'(TOTAL - 32'd1);
  localparam logic [CW-1:0] CNT_HIGH = CW'(WR_HIGH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          wr_n_q, wr_n_d;
  logic          rs_q, rs_d;
  logic [15:0]   data_q, data_d;

  // Down-counter spans both phases; wr_n is low while the count is in the upper part
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    rs_d     = rs_q;
    data_d   = data_q;
    if (go) begin
      active_d = 1'b1;
      cnt_d    = CNT_LOAD;
      rs_d     = rs_in;
      data_d   = data_in;
    end else if (active_q) begin
      if (cnt_q == CNT_ZERO) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else begin
      active_d = 1'b0;
    end
    wr_n_d = ~(active_d && (cnt_d >= CNT_HIGH));
  end

  // Strobe registers; reset abandons any write in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= CNT_ZERO;
      active_q <= 1'b0;
      wr_n_q   <= 1'b1;
      rs_q     <= 1'b0;
      data_q   <= 16'h0000;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      wr_n_q   <= wr_n_d;
      rs_q     <= rs_d;
      data_q   <= data_d;
    end
  end

  assign wr_n     = wr_n_q;
  assign rs_out   = rs_q;
  assign data_out = data_q;
  assign done     = active_q && (cnt_q == CNT_ZERO);

endmodule

// File: rtl/lcd_8080_writer.sv
// Turns the DMA pixel stream and single CPU writes into 8080-style LCD bus
// write cycles; each frame is prefixed by the memory-write opcode.
module lcd_8080_writer
  import lcd_pkg::*;
#(
  parameter int unsigned WR_LOW    = WR_LOW_DEF,
  parameter int unsigned WR_HIGH   = WR_HIGH_DEF,
  parameter logic [15:0] MEMWR_CMD = MEMWR_CMD_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_valid,
  output logic        reg_ready,
  input  logic        reg_rs,
  input  logic [15:0] reg_data,
  input  logic        frame_start,
  output logic        busy,
  output logic        frame_done,
  output logic [31:0] pix_count,
  input  logic        valid_dev,
  output logic        ready_dev,
  input  logic        last_dev,
  input  logic [15:0] data_dev,
  output logic        lcd_cs_n,
  output logic        lcd_rs,
  output logic        lcd_wr_n,
  output logic        lcd_rd_n,
  output logic [15:0] lcd_data
);

  lcd_state_e  state_q, state_d;
  logic        last_pend_q, last_pend_d;
  logic [31:0] pix_count_q, pix_count_d;
  logic        cs_n_q, cs_n_d;
  logic        frame_done_q, frame_done_d;

  logic        wr_go;
  logic        wr_rs;
  logic [15:0] wr_data;
  logic        wr_done;
  logic        ready_dev_raw;
  logic        reg_ready_raw;

  lcd_wr_strobe #(
    .WR_LOW  (WR_LOW),
    .WR_HIGH (WR_HIGH)
  ) u_strobe (
    .clk      (clk),
    .reset    (reset),
    .go       (wr_go),
    .rs_in    (wr_rs),
    .data_in  (wr_data),
    .wr_n     (lcd_wr_n),
    .rs_out   (lcd_rs),
    .data_out (lcd_data),
    .done     (wr_done)
  );

  // Next-state, write launch and handshake decode
  always_comb begin
    state_d       = state_q;
    last_pend_d   = last_pend_q;
    pix_count_d   = pix_count_q;
    wr_go         = 1'b0;
    wr_rs         = 1'b0;
    wr_data       = 16'h0000;
    ready_dev_raw = 1'b0;
    reg_ready_raw = 1'b0;
    case (state_q)
      ST_IDLE: begin
        reg_ready_raw = ~frame_start;
        if (frame_start) begin
          state_d     = ST_FRM_CMD;
          pix_count_d = 32'd0;
          last_pend_d = 1'b0;
          wr_go       = 1'b1;
          wr_rs       = 1'b0;
          wr_data     = MEMWR_CMD;
        end else if (reg_valid) begin
          state_d = ST_REG_WR;
          wr_go   = 1'b1;
          wr_rs   = reg_rs;
          wr_data = reg_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REG_WR: begin
        if (wr_done) state_d = ST_IDLE;
        else         state_d = ST_REG_WR;
      end
      ST_FRM_CMD: begin
        if (wr_done) state_d = ST_STREAM;
        else         state_d = ST_FRM_CMD;
      end
      ST_STREAM: begin
        ready_dev_raw = ~last_dev;
        if (last_dev) begin
          state_d = ST_DONE;
        end else if (valid_dev) begin
          state_d     = ST_PIX_WR;
          pix_count_d = pix_count_q + 32'd1;
          wr_go       = 1'b1;
          wr_rs       = 1'b1;
          wr_data     = data_dev;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_PIX_WR: begin
        // last_dev may arrive mid-write; remember it so the write finishes first
        if (last_dev) last_pend_d = 1'b1;
        else          last_pend_d = last_pend_q;
        if (wr_done) begin
          if (last_pend_q || last_dev) state_d = ST_DONE;
          else                         state_d = ST_STREAM;
        end else begin
          state_d = ST_PIX_WR;
        end
      end
      ST_DONE: begin
        last_pend_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cs_n_d       = ~(state_d inside {ST_REG_WR, ST_FRM_CMD, ST_STREAM, ST_PIX_WR});
    frame_done_d = (state_d == ST_DONE);
  end

  // State, frame bookkeeping and registered bus controls
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_pend_q  <= 1'b0;
      pix_count_q  <= 32'd0;
      cs_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_pend_q  <= last_pend_d;
      pix_count_q  <= pix_count_d;
      cs_n_q       <= cs_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ready_dev  = ready_dev_raw & ~reset;
  assign reg_ready  = reg_ready_raw & ~reset;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign pix_count  = pix_count_q;
  assign lcd_cs_n   = cs_n_q;
  assign lcd_rd_n   = 1'b1;

endmodule

// File: tb/tb_lcd_8080_writer.sv
// Self-checking bench: a cycle-window reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lcd_8080_writer;

  localparam int WL = 2;
  localparam int WH = 2;
  localparam logic [15:0] OPC = 16'h002C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reg_valid = 1'b0;
  logic        reg_rs = 1'b0;
  logic [15:0] reg_data = 16'h0000;
  logic        frame_start = 1'b0;
  logic        valid_dev = 1'b0;
  logic        last_dev = 1'b0;
  logic [15:0] data_dev = 16'h0000;
  logic        reg_ready, busy, frame_done, ready_dev;
  logic [31:0] pix_count;
  logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n;
  logic [15:0] lcd_data;

  lcd_8080_writer dut (
    .clk(clk), .reset(reset),
    .reg_valid(reg_valid), .reg_ready(reg_ready), .reg_rs(reg_rs), .reg_data(reg_data),
    .frame_start(frame_start), .busy(busy), .frame_done(frame_done), .pix_count(pix_count),
    .valid_dev(valid_dev), .ready_dev(ready_dev), .last_dev(last_dev), .data_dev(data_dev),
    .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n), .lcd_rd_n(lcd_rd_n),
    .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a write is a window of cycles [m_beg, m_end]; a frame is
  // open from frame_start until its done cycle.
  int          cyc = 0;
  int          m_beg = 0, m_end = -1, m_done_at = -1;
  bit          m_pix = 1'b0, m_frame = 1'b0, m_saw = 1'b0;
  logic [31:0] m_cnt = 32'd0;
  logic [15:0] m_data = 16'h0000;
  bit          m_rs = 1'b0;

  always @(negedge clk) begin : model
    bit wr, dc, idle, slot;
    wr   = (cyc >= m_beg) && (cyc <= m_end);
    dc   = m_frame && (cyc == m_done_at);
    idle = !m_frame && !wr;
    slot = m_frame && !wr && !dc;
    if (chk_en) begin
      chk("cs_n",       lcd_cs_n,   !(wr || (m_frame && !dc)));
      chk("wr_n",       lcd_wr_n,   !(wr && (cyc < m_beg + WL)));
      chk("rd_n",       lcd_rd_n,   1);
      chk("rs",         lcd_rs,     m_rs);
      chk("data",       lcd_data,   m_data);
      chk("busy",       busy,       !idle);
      chk("frame_done", frame_done, dc);
      chk("pix_count",  pix_count,  m_cnt);
      chk("ready_dev",  ready_dev,  !reset && slot && !last_dev);
      chk("reg_ready",  reg_ready,  !reset && idle && !frame_start);
    end
    if (reset) begin
      m_beg = 0; m_end = -1; m_done_at = -1;
      m_frame = 0; m_saw = 0; m_pix = 0;
      m_cnt = 0; m_data = 0; m_rs = 0;
    end else if (idle) begin
      if (frame_start) begin
        m_frame = 1; m_cnt = 0; m_saw = 0;
        m_beg = cyc + 1; m_end = cyc + WL + WH; m_data = OPC; m_rs = 0; m_pix = 0;
      end else if (reg_valid) begin
        m_beg = cyc + 1; m_end = cyc + WL + WH; m_data = reg_data; m_rs = reg_rs; m_pix = 0;
      end
    end else if (dc) begin
      m_frame = 0; m_done_at = -1; m_saw = 0;
    end else if (m_frame && wr) begin
      if (m_pix && last_dev) m_saw = 1;
      if (cyc == m_end && m_pix && m_saw) m_done_at = cyc + 1;
    end else if (slot) begin
      if (last_dev) m_done_at = cyc + 1;
      else if (valid_dev) begin
        m_cnt = m_cnt + 1;
        m_beg = cyc + 1; m_end = cyc + WL + WH; m_data = data_dev; m_rs = 1; m_pix = 1;
      end
    end
    cyc++;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    nxt();
    frame_start = 1'b0;
    repeat (4) nxt();
  endtask

  logic [15:0] pix_tbl [3];

  initial begin
    pix_tbl[0] = 16'hF800; pix_tbl[1] = 16'h07E0; pix_tbl[2] = 16'h001F;
    @(posedge clk); #1;
    chk_en = 1'b1;
    nxt();
    reset = 1'b0;
    smp();
    chk("rst_cs_n", lcd_cs_n, 1); chk("rst_wr_n", lcd_wr_n, 1);
    chk("rst_data", lcd_data, 0); chk("rst_pix", pix_count, 0);
    chk("rst_busy", busy, 0);     chk("rst_fd", frame_done, 0);

    // single command write
    nxt(); reg_valid = 1'b1; reg_rs = 1'b0; reg_data = 16'h0011;
    smp(); chk("cmd_accept", reg_ready, 1);
    nxt(); reg_valid = 1'b0;
    smp(); chk("cmd_t1_wr", lcd_wr_n, 0); chk("cmd_t1_cs", lcd_cs_n, 0); chk("cmd_data", lcd_data, 16'h0011);
    nxt(); smp(); chk("cmd_t2_wr", lcd_wr_n, 0);
    nxt(); smp(); chk("cmd_t3_wr", lcd_wr_n, 1); chk("cmd_t3_cs", lcd_cs_n, 0);
    nxt(); smp(); chk("cmd_t4_wr", lcd_wr_n, 1); chk("cmd_t4_cs", lcd_cs_n, 0);
    nxt(); smp(); chk("cmd_t5_rdy", reg_ready, 1); chk("cmd_t5_cs", lcd_cs_n, 1);

    // three-pixel frame
    frame_start = 1'b1;
    smp(); chk("frm_regrdy", reg_ready, 0);
    nxt(); frame_start = 1'b0;
    smp(); chk("frm_opc", lcd_data, 16'h002C); chk("frm_opc_rs", lcd_rs, 0);
    repeat (3) nxt();
    for (int i = 0; i < 3; i++) begin
      nxt(); valid_dev = 1'b1; data_dev = pix_tbl[i];
      smp(); chk("frm_ready", ready_dev, 1);
      nxt(); valid_dev = 1'b0;
      smp(); chk("frm_pix", lcd_data, {16'h0000, pix_tbl[i]}); chk("frm_pix_rs", lcd_rs, 1);
      repeat (3) nxt();
    end
    nxt(); last_dev = 1'b1;
    nxt(); last_dev = 1'b0;
    smp(); chk("frm_done", frame_done, 1); chk("frm_cs", lcd_cs_n, 1); chk("frm_cnt", pix_count, 3);
    nxt(); smp(); chk("frm_idle", busy, 0); chk("frm_cnt_hold", pix_count, 3);

    // last_dev during a pixel write
    start_frame();
    valid_dev = 1'b1; data_dev = 16'h1234;
    nxt(); valid_dev = 1'b0; last_dev = 1'b1;
    smp(); chk("lp_data", lcd_data, 16'h1234);
    repeat (3) nxt();
    smp(); chk("lp_wr_end", lcd_wr_n, 1);
    nxt(); smp(); chk("lp_done", frame_done, 1); chk("lp_cnt", pix_count, 1);
    nxt(); last_dev = 1'b0;

    // frame_start and reg_valid together; also a zero-pixel frame
    frame_start = 1'b1; reg_valid = 1'b1; reg_rs = 1'b1; reg_data = 16'h00A5;
    smp(); chk("both_regrdy", reg_ready, 0);
    nxt(); frame_start = 1'b0;
    repeat (4) nxt();
    last_dev = 1'b1;
    nxt(); last_dev = 1'b0;
    smp(); chk("zp_done", frame_done, 1); chk("zp_cnt", pix_count, 0);
    nxt(); smp(); chk("both_late_rdy", reg_ready, 1);
    nxt(); reg_valid = 1'b0;
    smp(); chk("both_reg_data", lcd_data, 16'h00A5); chk("both_reg_cs", lcd_cs_n, 0);
    repeat (4) nxt();

    // reset in the middle of a pixel write
    start_frame();
    valid_dev = 1'b1; data_dev = 16'hBEEF;
    nxt(); valid_dev = 1'b0;
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0;
    smp(); chk("rm_cs", lcd_cs_n, 1); chk("rm_wr", lcd_wr_n, 1); chk("rm_rdy", ready_dev, 0);
    chk("rm_busy", busy, 0); chk("rm_cnt", pix_count, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      nxt();
      frame_start = ($urandom_range(0, 39) == 0);
      reg_valid   = ($urandom_range(0, 3) == 0);
      reg_rs      = 1'($urandom_range(0, 1));
      reg_data    = 16'($urandom);
      valid_dev   = 1'($urandom_range(0, 1));
      data_dev    = 16'($urandom);
      last_dev    = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 399) == 0);
    end
    nxt();
    frame_start = 1'b0; reg_valid = 1'b0; valid_dev = 1'b0; last_dev = 1'b0; reset = 1'b0;
    smp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_8080_writer.md
Name: lcd_8080_writer

Overview:
- Device-side consumer of the DMA 16-bit pixel stream (valid_dev/ready_dev/last_dev/data_dev).
- Converts the stream into Intel-8080-style parallel LCD write cycles (CS#, RS, WR#, RD#, D[15:0]).
- Also issues single CPU-requested command/parameter writes while no frame is in progress.
- A frame first sends the memory-write opcode with RS=0, then streams pixels with RS=1 until last_dev is seen.

Parameters:
WR_LOW, 2, cycles wr_n is held low per write (>=1)
WR_HIGH, 2, cycles wr_n is held high per write after the low phase (>=1)
MEMWR_CMD, 16'h002C, opcode sent with RS=0 at the start of every frame

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
reg_valid  in  1  CPU single-write request
reg_ready  out  1  request accepted when reg_valid&reg_ready
reg_rs  in  1  RS level for the single write (0=command, 1=data)
reg_data  in  16  word for the single write
frame_start  in  1  one-cycle pulse that begins a frame
busy  out  1  high whenever state != IDLE
frame_done  out  1  one-cycle pulse when a frame ends
pix_count  out  32  pixels accepted in the current/last frame
valid_dev  in  1  stream data valid
ready_dev  out  1  stream data ready
last_dev  in  1  end-of-stream marker; never carries data
data_dev  in  16  pixel (RGB565)
lcd_cs_n  out  1  chip select, active low
lcd_rs  out  1  register select
lcd_wr_n  out  1  write strobe, active low
lcd_rd_n  out  1  read strobe; constant 1
lcd_data  out  16  parallel bus

Behaviour:
- Reset: one clk; synchronous, active-high.
  - State returns to IDLE.
  - Registered outputs: lcd_cs_n=1, lcd_wr_n=1, lcd_rd_n=1, lcd_rs=0, lcd_data=0, pix_count=0, frame_done=0, last_pend=0.
  - Combinational outputs ready_dev and reg_ready are forced 0 while reset=1.
  - Reset mid-write aborts the write immediately; the next cycle shows idle bus levels.
- States: IDLE, REG_WR, FRM_CMD, STREAM, PIX_WR, DONE.
- Write engine (shared by REG_WR/FRM_CMD/PIX_WR):
  - lcd_data and lcd_rs are loaded on entry.
  - lcd_wr_n=0 for WR_LOW cycles, then 1 for WR_HIGH cycles.
  - A down-counter times both phases.
  - lcd_data and lcd_rs are stable over the whole write.
- IDLE:
  - reg_ready = ~frame_start.
  - frame_start has priority: go to FRM_CMD and clear pix_count.
  - Otherwise reg_valid&reg_ready goes to REG_WR.
  - frame_start is ignored in every other state.
- REG_WR:
  - lcd_cs_n=0 for the write only.
  - Returns to IDLE after WR_LOW+WR_HIGH cycles.
  - lcd_cs_n=1 in the IDLE cycle.
- FRM_CMD:
  - lcd_cs_n=0, write MEMWR_CMD with rs=0, then go to STREAM.
  - lcd_cs_n stays 0 from FRM_CMD entry until DONE.
- STREAM:
  - ready_dev = ~last_dev (combinational).
  - valid_dev&ready_dev latches data_dev, increments pix_count (wraps at 2^32) and enters PIX_WR with rs=1.
  - last_dev=1 goes to DONE; no data is accepted that cycle.
- PIX_WR:
  - ready_dev=0.
  - last_dev seen during PIX_WR sets last_pend.
  - When the write completes: go to DONE if last_pend, else STREAM.
  - Per-pixel period = 1 + WR_LOW + WR_HIGH cycles.
- DONE (one cycle):
  - lcd_cs_n=1, frame_done=1, last_pend cleared, then IDLE.
  - pix_count holds its value until the next frame_start.
- busy=1 in every state except IDLE.
- A frame with zero pixels (last_dev straight after the opcode) is legal: only the opcode write occurs.

Decomposition:
- Package lcd_pkg holds:
  - the state encodings (3-bit);
  - the default timing constants;
  - the MEMWR_CMD default.
- One sub-module, lcd_wr_strobe: the timing engine.
  - Inputs: go, rs, data.
  - Outputs: wr_n, rs, data, done.
  - done is a pulse in the final WR_HIGH cycle.
- The top module holds the FSM, last_pend and pix_count.

Test Plan:
- Single command write, defaults: reg_valid=1, reg_rs=0, reg_data=16'h0011 accepted at T -> cs_n=0 T+1..T+4; wr_n=0 at T+1,T+2; wr_n=1 at T+3,T+4; data=0011, rs=0; reg_ready=1 again at T+5.
- Three-pixel frame: frame_start at T -> 002C written with rs=0 over T+1..T+4; ready_dev=1 at T+5; pixels F800, 07E0, 001F each written with rs=1 (5-cycle period); last_dev -> frame_done pulse, cs_n=1, pix_count=3.
- last_dev during PIX_WR -> current write finishes intact, then DONE with no further ready_dev.
- frame_start and reg_valid in the same IDLE cycle -> frame begins, reg_ready=0, and the reg write is serviced after DONE.
- Reset asserted mid-PIX_WR -> next cycle cs_n=1, wr_n=1, ready_dev=0, busy=0, pix_count=0.
- Zero-pixel frame: last_dev at first STREAM cycle -> only the 002C write occurs, frame_done pulses, pix_count=0.
